rx_symbol_recovery: RTL and testbench

RX_SYMBOL_RECOVERY -- requirements
Module: rx_symbol_recovery

---
 rtl/rx_symbol_recovery.sv | 81 ++++++++
 tb/tb_rx_symbol_recovery.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_symbol_recovery.sv
// rx_symbol_recovery: decimating sign slicer with optional BER counters (enable with macro RX_BER_COUNTER_EN)
module rx_symbol_recovery #(
    parameter int N_OS    = 4,
    parameter int NB_I    = 9,
    parameter int NBF_I   = 7,
    parameter int NB_CNT  = 32,
    parameter int MAX_DLY = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic                       i_sym_strobe,
    input  logic [NB_I-1:0]            i_sample,
    input  logic [$clog2(N_OS)-1:0]    i_phase,
    input  logic [1:0]                 i_ref_ak,
    input  logic [$clog2(MAX_DLY)-1:0] i_delay,
    input  logic                       i_clr_cnt,
    output logic [1:0]                 o_ak,
    output logic                       o_ak_valid,
    output logic [NB_CNT-1:0]          o_err_cnt,
    output logic [NB_CNT-1:0]          o_sym_cnt
);
    localparam int NB_PH = $clog2(N_OS);
    logic [NB_PH-1:0] cnt;
    logic [NB_PH-1:0] act;
    logic [NB_PH-1:0] ph;
    logic [NB_PH-1:0] sel;
    logic             dec;
    logic             unused_ok;
    // A strobe forces phase 0; at phase 0 the freshly presented i_phase governs this symbol,
    // so a phase change never drops or doubles a decision.
    assign ph  = i_sym_strobe ? '0 : cnt;
    assign sel = (ph == '0) ? i_phase : act;
    assign dec = i_valid && (ph == sel);
    // Phase tracking, active-phase capture and registered sign decision.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt        <= '0;
            act        <= '0;
            o_ak       <= 2'b00;
            o_ak_valid <= 1'b0;
        end else begin
            o_ak_valid <= dec;
            if (i_valid) begin
                cnt <= ph + 1'b1;
                if (ph == '0) act <= i_phase;
            end
            if (dec) o_ak <= i_sample[NB_I-1] ? 2'b11 : 2'b01;
        end
    end
`ifdef RX_BER_COUNTER_EN
    logic [MAX_DLY-1:0] dly;
    logic [MAX_DLY:0]   taps;
    logic               miss;
    // Only reference sign bits are kept; tap 0 is the reference arriving with this decision.
    assign taps      = {dly, i_ref_ak[1]};
    assign miss      = taps[i_delay] ^ i_sample[NB_I-1];
    assign unused_ok = ^{i_ref_ak[0], i_sample[NB_I-2:0], 1'(NBF_I)};
    // Reference delay line and saturating error/symbol counters; clear beats a decision.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dly       <= '0;
            o_err_cnt <= '0;
            o_sym_cnt <= '0;
        end else begin
            if (dec) dly <= {dly[MAX_DLY-2:0], i_ref_ak[1]};
            if (i_clr_cnt) begin
                o_err_cnt <= '0;
                o_sym_cnt <= '0;
            end else if (dec && !(&o_sym_cnt)) begin
                o_sym_cnt <= o_sym_cnt + 1'b1;
                o_err_cnt <= o_err_cnt + NB_CNT'(miss);
            end
        end
    end
`else
    assign o_err_cnt = '0;
    assign o_sym_cnt = '0;
    assign unused_ok = ^{i_ref_ak, i_delay, i_clr_cnt, i_sample[NB_I-2:0], 1'(NBF_I)};
`endif
endmodule

// File: tb/tb_rx_symbol_recovery.sv
// tb_rx_symbol_recovery: directed table and sequence checks for rx_symbol_recovery
module tb_rx_symbol_recovery;
    typedef struct {
        logic       v;
        logic       s;
        logic [8:0] x;
        logic [1:0] p;
        logic       ev;
        logic [1:0] eak;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, strobe = 1'b0, clr = 1'b0;
    logic [8:0]  smp = '0;
    logic [1:0]  phase = '0, ref_ak = 2'b01;
    logic [4:0]  dly = '0;
    logic [1:0]  ak, ak2;
    logic        akv, akv2;
    logic [31:0] err, sym;
    logic [2:0]  err2, sym2;
    int          total = 0, bad = 0;
    vec_t        tbl[34];
    logic        bits[0:199];

    always #5 clk = ~clk;

    rx_symbol_recovery dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_sym_strobe(strobe), .i_sample(smp),
        .i_phase(phase), .i_ref_ak(ref_ak), .i_delay(dly), .i_clr_cnt(clr),
        .o_ak(ak), .o_ak_valid(akv), .o_err_cnt(err), .o_sym_cnt(sym)
    );

    rx_symbol_recovery #(.NB_CNT(3)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_sym_strobe(strobe), .i_sample(smp),
        .i_phase(phase), .i_ref_ak(ref_ak), .i_delay(dly), .i_clr_cnt(clr),
        .o_ak(ak2), .o_ak_valid(akv2), .o_err_cnt(err2), .o_sym_cnt(sym2)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input int v, input int s, input int x, input int p, input int ev, input int eak);
        vec_t r;
        r.v = 1'(v); r.s = 1'(s); r.x = 9'(x); r.p = 2'(p); r.ev = 1'(ev); r.eak = 2'(eak);
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndec, nneg, n, e;
        tbl[0]  = mk(1,1, 100,2,0,0); tbl[1]  = mk(1,0, 100,2,0,0);
        tbl[2]  = mk(1,0, 100,2,1,1); tbl[3]  = mk(1,0, 100,2,0,1);
        tbl[4]  = mk(1,1,-100,2,0,1); tbl[5]  = mk(1,0,-100,2,0,1);
        tbl[6]  = mk(1,0,-100,2,1,3); tbl[7]  = mk(1,0,-100,2,0,3);
        tbl[8]  = mk(1,1,  50,0,1,1); tbl[9]  = mk(1,0,  50,3,0,1);
        tbl[10] = mk(1,0,  50,3,0,1); tbl[11] = mk(1,0,  50,3,0,1);
        tbl[12] = mk(1,1,   5,3,0,1); tbl[13] = mk(1,0,   5,3,0,1);
        tbl[14] = mk(1,0,   5,3,0,1); tbl[15] = mk(1,0,  -1,3,1,3);
        tbl[16] = mk(1,0,  -7,3,0,3); tbl[17] = mk(0,1,  -7,3,0,3);
        tbl[18] = mk(0,0,  -7,3,0,3); tbl[19] = mk(1,0,  -7,3,0,3);
        tbl[20] = mk(0,0,  -7,3,0,3); tbl[21] = mk(0,0,  -7,3,0,3);
        tbl[22] = mk(1,0,  -7,3,0,3); tbl[23] = mk(0,1,  -7,3,0,3);
        tbl[24] = mk(1,0,   0,3,1,1); tbl[25] = mk(1,1,  -3,1,0,1);
        tbl[26] = mk(1,0,  -3,1,1,3); tbl[27] = mk(1,0,   3,1,0,3);
        tbl[28] = mk(1,1,   3,1,0,3); tbl[29] = mk(1,0,   3,1,1,1);
        tbl[30] = mk(1,0,   3,1,0,1); tbl[31] = mk(1,0,   0,1,0,1);
        tbl[32] = mk(1,0,-256,0,1,3); tbl[33] = mk(1,0, 255,0,0,3);

        cyc(); cyc();
        chk("reset_ak", ak, 2'b00);
        chk("reset_akv", akv, 1'b0);
        chk("reset_err", err, 0);
        chk("reset_sym", sym, 0);
        rst = 1'b0;

        ndec = 0; nneg = 0;
        for (int i = 0; i < 34; i++) begin
            valid = tbl[i].v; strobe = tbl[i].s; smp = tbl[i].x; phase = tbl[i].p;
            cyc();
            chk($sformatf("tbl%0d_akv", i), akv, tbl[i].ev);
            chk($sformatf("tbl%0d_ak", i), ak, tbl[i].eak);
            if (tbl[i].ev) begin
                ndec++;
                if (tbl[i].eak == 2'b11) nneg++;
            end
        end
`ifdef RX_BER_COUNTER_EN
        chk("tbl_sym_cnt", sym, 32'(ndec));
        chk("tbl_err_cnt", err, 32'(nneg));
`else
        chk("tbl_sym_cnt_tied", sym, 0);
        chk("tbl_err_cnt_tied", err, 0);
`endif

        // asynchronous reset in the middle of a symbol
        valid = 1'b1; strobe = 1'b1; phase = 2'd2; smp = 9'd20;
        cyc();
        strobe = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ak", ak, 2'b00);
        chk("async_rst_akv", akv, 1'b0);
        chk("async_rst_sym", sym, 0);
        cyc();
        rst = 1'b0; phase = 2'd1; smp = 9'(-9);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("post_rst%0d_akv", i), akv, (i == 1 || i == 5));
            if (i == 1) chk("post_rst_ak", ak, 2'b11);
        end

        // gapped valid: one valid sample in three cycles
        valid = 1'b0;
        pulse_reset();
        phase = 2'd3; smp = 9'd10; n = 0;
        for (int i = 0; i < 72; i++) begin
            valid = (i % 3 == 0);
            cyc();
            if (akv) n++;
        end
        valid = 1'b0;
        cyc();
        if (akv) n++;
        chk("gapped_decisions", n, 6);

`ifdef RX_BER_COUNTER_EN
        // BER against a reference leading the decisions by 5 symbols
        for (int k = 0; k < 200; k++) bits[k] = (k < 5) ? 1'b0 : 1'($urandom_range(1, 0));
        pulse_reset();
        dly = 5'd5; phase = 2'd0;
        for (int k = 0; k < 173; k++) begin
            if (k == 132) begin
                chk("ber_d5_err", err, 0);
                chk("ber_d5_sym", sym, 132);
            end
            if (k == 133) begin
                dly = 5'd4;
                chk("clr_err", err, 0);
                chk("clr_sym", sym, 0);
            end
            for (int p = 0; p < 4; p++) begin
                valid = 1'b1; strobe = (p == 0); clr = (k == 132 && p == 0);
                smp = bits[k] ? 9'(-100) : 9'd100;
                ref_ak = bits[k + 5] ? 2'b11 : 2'b01;
                cyc();
            end
            clr = 1'b0;
        end
        e = 0;
        for (int k = 133; k < 173; k++) if (bits[k] != bits[k + 1]) e++;
        chk("ber_d4_sym", sym, 40);
        chk("ber_d4_err", err, 32'(e));

        // saturation on the narrow-counter instance
        pulse_reset();
        dly = 5'd0; phase = 2'd0; smp = 9'd50;
        for (int k = 0; k < 10; k++) begin
            for (int p = 0; p < 4; p++) begin
                valid = 1'b1; strobe = (p == 0);
                ref_ak = (k < 7) ? 2'b01 : 2'b11;
                cyc();
            end
            if (k == 6) begin
                chk("sat_sym_full", sym2, 3'd7);
                chk("sat_err_before", err2, 3'd0);
            end
        end
        chk("sat_sym_held", sym2, 3'd7);
        chk("sat_err_held", err2, 3'd0);
        chk("wide_sym", sym, 10);
        chk("wide_err", err, 3);
`else
        chk("tied_err_final", err, 0);
        chk("tied_sym_final", sym2, 0);
`endif
        valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
